// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cfg
// Description : Runtime-configurable UART receiver (5..9 data bits, none/even/
//               odd parity, 1 or 2 stop bits) with 3-sample majority voting,
//               parity/framing/break/overrun status and a ready/valid holding
//               register.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cfg #(
  parameter int MAX_DATA_WIDTH  = 9,
  parameter int OVERSAMPLE_RATE = 16
) (
  input  logic                      uart_clk,
  input  logic                      rst_n,
  input  logic                      sample_tick,
  input  logic                      rx_serial_sync,
  input  logic [3:0]                cfg_data_bits,
  input  logic [1:0]                cfg_parity,
  input  logic                      cfg_stop2,
  output logic [MAX_DATA_WIDTH-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      parity_error,
  output logic                      frame_error,
  output logic                      break_detect,
  output logic                      overrun,
  output logic                      rx_active
);

  localparam int CNT_W = $clog2(OVERSAMPLE_RATE);
  localparam int MID   = OVERSAMPLE_RATE / 2;

  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);
  localparam logic [CNT_W-1:0] CNT_POST = CNT_W'(MID + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE_RATE - 1);

  localparam logic [3:0] MIN_BITS = 4'd5;
  localparam logic [3:0] MAX_BITS = 4'(MAX_DATA_WIDTH);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP1     = 3'd4;
  localparam logic [2:0] STOP2     = 3'd5;
  localparam logic [2:0] WAIT_HIGH = 3'd6;

  logic [2:0]                state;
  logic [CNT_W-1:0]          cnt;
  logic [3:0]                bit_idx;
  logic [3:0]                nbits;
  logic                      par_en;
  logic                      par_odd;
  logic                      stop2_q;
  logic                      samp_pre;
  logic                      samp_mid;
  logic [MAX_DATA_WIDTH-1:0] shreg;
  logic                      par_err;
  logic                      frm_err;
  logic                      seen_one;

  logic [3:0]                bits_clamped;
  logic                      maj;
  logic                      decide;
  logic                      bit_end;
  logic                      last_stop;
  logic                      frame_done;
  logic                      done_fe;
  logic                      done_brk;

  // Clamp the requested word length into the supported range
  always_comb begin
    bits_clamped = cfg_data_bits;
    if (cfg_data_bits < MIN_BITS)      bits_clamped = MIN_BITS;
    else if (cfg_data_bits > MAX_BITS) bits_clamped = MAX_BITS;
  end

  // The live line is the third vote, taken on the deciding tick itself
  assign maj = (samp_pre & samp_mid) | (samp_pre & rx_serial_sync) |
               (samp_mid & rx_serial_sync);

  assign decide     = sample_tick && (cnt == CNT_POST);
  assign bit_end    = sample_tick && (cnt == CNT_LAST);
  assign last_stop  = (state == STOP2) || ((state == STOP1) && !stop2_q);
  assign frame_done = decide && last_stop;
  assign done_fe    = frm_err | ~maj;
  assign done_brk   = ~(seen_one | maj);
  assign rx_active  = (state != IDLE);

  // Frame sequencer: bit timing, voting, data capture and per-frame status
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      nbits    <= MIN_BITS;
      par_en   <= 1'b0;
      par_odd  <= 1'b0;
      stop2_q  <= 1'b0;
      samp_pre <= 1'b1;
      samp_mid <= 1'b1;
      shreg    <= '0;
      par_err  <= 1'b0;
      frm_err  <= 1'b0;
      seen_one <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_serial_sync) begin
            state    <= START;
            cnt      <= '0;
            bit_idx  <= '0;
            nbits    <= bits_clamped;
            par_en   <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            par_odd  <= (cfg_parity == 2'b10);
            stop2_q  <= cfg_stop2;
            shreg    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            seen_one <= 1'b0;
          end
        end
        WAIT_HIGH: begin
          if (rx_serial_sync) state <= IDLE;
        end
        default: begin
          if (sample_tick) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            if (cnt == CNT_PRE) samp_pre <= rx_serial_sync;
            if (cnt == CNT_MID) samp_mid <= rx_serial_sync;
          end
          if (decide) begin
            case (state)
              START: begin
                if (maj) state <= IDLE;
              end
              DATA: begin
                shreg[bit_idx] <= maj;
                seen_one       <= seen_one | maj;
              end
              PARITY: begin
                par_err  <= (^shreg) ^ maj ^ par_odd;
                seen_one <= seen_one | maj;
              end
              default: begin
                if (!maj) frm_err <= 1'b1;
                seen_one <= seen_one | maj;
                if (last_stop) state <= rx_serial_sync ? IDLE : WAIT_HIGH;
              end
            endcase
          end
          if (bit_end) begin
            case (state)
              START:  state <= DATA;
              DATA: begin
                if (bit_idx == nbits - 4'd1) state <= par_en ? PARITY : STOP1;
                else                         bit_idx <= bit_idx + 4'd1;
              end
              PARITY: state <= STOP1;
              STOP1:  state <= STOP2;
              default: state <= state;
            endcase
          end
        end
      endcase
    end
  end

  // Holding register: load when free or emptied this cycle, else count a drop
  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      parity_error <= 1'b0;
      frame_error  <= 1'b0;
      break_detect <= 1'b0;
      overrun      <= 1'b0;
    end else if (frame_done && (!rx_valid || rx_ready)) begin
      rx_data      <= shreg;
      parity_error <= par_err;
      frame_error  <= done_fe;
      break_detect <= done_brk;
      rx_valid     <= 1'b1;
      overrun      <= 1'b0;
    end else if (frame_done) begin
      overrun <= 1'b1;
    end else if (rx_valid && rx_ready) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_cfg
// Description : Self-checking bench for uart_rx_cfg: directed scenarios plus
//               randomized frames checked against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

  localparam int MID = 8;

  logic       uart_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_tick = 1'b0;
  logic       rx_serial_sync = 1'b1;
  logic [3:0] cfg_data_bits = 4'd8;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_stop2 = 1'b0;
  logic       rx_ready = 1'b0;
  logic [8:0] rx_data;
  logic       rx_valid, parity_error, frame_error, break_detect, overrun, rx_active;

  int n_checks = 0;
  int n_errors = 0;
  int ticks = 0;
  int tick_div = 0;
  int start_ticks = 0;
  int rise_ticks = -1;
  logic prev_valid = 1'b0;

  // Frame-level model state
  logic [15:0] fbits;
  int          fnb;
  logic [8:0]  exp_data;
  logic        exp_pe, exp_fe, exp_brk;
  int          exp_lat;

  uart_rx_cfg #(.MAX_DATA_WIDTH(9), .OVERSAMPLE_RATE(16)) dut (
    .uart_clk(uart_clk), .rst_n(rst_n), .sample_tick(sample_tick),
    .rx_serial_sync(rx_serial_sync), .cfg_data_bits(cfg_data_bits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .parity_error(parity_error),
    .frame_error(frame_error), .break_detect(break_detect), .overrun(overrun),
    .rx_active(rx_active)
  );

  always #5 uart_clk = ~uart_clk;

  // One sample tick every fourth clock
  initial begin
    forever begin
      @(posedge uart_clk);
      #1;
      tick_div = (tick_div + 1) % 4;
      sample_tick = (tick_div == 0);
      if (sample_tick) ticks++;
    end
  end

  // Record the tick index at which rx_valid rises
  always @(negedge uart_clk) begin
    if (rx_valid && !prev_valid) rise_ticks <= ticks;
    prev_valid <= rx_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge uart_clk); while (!sample_tick);
  endtask

  // Build the serial bit sequence and expected results from the frame rules
  task automatic build_frame(input logic [8:0] val, input int n, input logic [1:0] par,
                             input logic st2, input logic flip, input logic [1:0] stops);
    int nn, k;
    logic x, p, pen;
    nn = (n < 5) ? 5 : (n > 9) ? 9 : n;
    exp_data = '0;
    for (int i = 0; i < nn; i++) exp_data[i] = val[i];
    fbits = '0;
    for (int i = 0; i < nn; i++) fbits[1+i] = exp_data[i];
    k = 1 + nn;
    x = ^exp_data;
    pen = (par == 2'b01) || (par == 2'b10);
    exp_pe = 1'b0;
    if (pen) begin
      p = (par == 2'b10) ? ~x : x;
      p = p ^ flip;
      fbits[k] = p;
      k++;
      exp_pe = ((x ^ p) != (par == 2'b10));
    end
    fbits[k] = stops[0];
    k++;
    if (st2) begin
      fbits[k] = stops[1];
      k++;
    end
    fnb = k;
    exp_fe = !stops[0] || (st2 && !stops[1]);
    exp_brk = 1'b1;
    for (int i = 1; i < fnb; i++) if (fbits[i]) exp_brk = 1'b0;
    exp_lat = (fnb - 1) * 16 + MID + 2;
  endtask

  // Drive fbits tick by tick; optional inverted sample, handshake or reset
  task automatic send_frame(input int glitch_t, input int hs_t, input int abort_t,
                            input logic scramble);
    wait_tick();
    #1;
    start_ticks = ticks;
    for (int t = 0; t < fnb * 16; t++) begin
      rx_serial_sync = fbits[t/16] ^ (t == glitch_t);
      if (scramble && t == 20) begin
        cfg_data_bits = 4'($urandom_range(0, 15));
        cfg_parity = 2'($urandom_range(0, 3));
        cfg_stop2 = 1'($urandom_range(0, 1));
      end
      if (t == abort_t) begin
        rst_n = 1'b0;
        break;
      end
      if (t == hs_t) begin
        repeat (3) @(posedge uart_clk);
        #1 rx_ready = 1'b1;
      end
      wait_tick();
      #1;
      if (t == hs_t) rx_ready = 1'b0;
    end
    rx_serial_sync = 1'b1;
  endtask

  task automatic accept();
    @(posedge uart_clk);
    #1 rx_ready = 1'b1;
    @(posedge uart_clk);
    #1 rx_ready = 1'b0;
    check("accept_valid", rx_valid, 1'b0);
    check("accept_overrun", overrun, 1'b0);
  endtask

  task automatic check_word(input string name);
    int lat;
    check({name, "_valid"}, rx_valid, 1'b1);
    check({name, "_data"}, rx_data, exp_data);
    check({name, "_perr"}, parity_error, exp_pe);
    check({name, "_ferr"}, frame_error, exp_fe);
    check({name, "_brk"}, break_detect, exp_brk);
    lat = rise_ticks - start_ticks;
    if (lat >= exp_lat - 1 && lat <= exp_lat + 1) lat = exp_lat;
    check({name, "_latency"}, lat, exp_lat);
  endtask

  task automatic run_frame(input string name, input logic [8:0] val, input int n,
                           input logic [1:0] par, input logic st2, input logic flip,
                           input logic [1:0] stops, input int glitch_bit,
                           input logic scr, input logic acc);
    cfg_data_bits = 4'(n);
    cfg_parity = par;
    cfg_stop2 = st2;
    build_frame(val, n, par, st2, flip, stops);
    send_frame((glitch_bit < 0) ? -1 : glitch_bit * 16 + MID, -1, -1, scr);
    repeat (2) @(posedge uart_clk);
    #1;
    check_word(name);
    if (acc) accept();
    repeat (16) wait_tick();
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge uart_clk);
    #1;
    check("rst_valid", rx_valid, 1'b0);
    check("rst_data", rx_data, 9'h000);
    check("rst_flags", {parity_error, frame_error, break_detect, overrun}, 4'b0000);
    check("rst_active", rx_active, 1'b0);
    rst_n = 1'b1;
    repeat (8) wait_tick();
    #1;

    // 8N1 0xA5, held under backpressure then accepted
    run_frame("8n1_a5", 9'h0A5, 8, 2'b00, 1'b0, 1'b0, 2'b11, -1, 1'b0, 1'b0);
    repeat (500) @(posedge uart_clk);
    #1;
    check("hold_valid", rx_valid, 1'b1);
    check("hold_data", rx_data, 9'h0A5);
    accept();

    // 7E1 good and bad parity, 5O2
    run_frame("7e1_ok", 9'h041, 7, 2'b01, 1'b0, 1'b0, 2'b11, -1, 1'b0, 1'b1);
    run_frame("7e1_bad", 9'h041, 7, 2'b01, 1'b0, 1'b1, 2'b11, -1, 1'b0, 1'b1);
    run_frame("5o2", 9'h015, 5, 2'b10, 1'b1, 1'b0, 2'b11, -1, 1'b0, 1'b1);

    // Break on 9N1: line low for 12 bit times
    cfg_data_bits = 4'd9; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    build_frame(9'h000, 9, 2'b00, 1'b0, 1'b0, 2'b00);
    fnb = 12;
    send_frame(-1, -1, -1, 1'b0);
    check("brk_wait_active", rx_active, 1'b1);
    repeat (2) @(posedge uart_clk);
    #1;
    check("brk_released_idle", rx_active, 1'b0);
    check_word("break");
    accept();
    repeat (16) wait_tick();
    #1;
    run_frame("9n1_1ff", 9'h1FF, 9, 2'b00, 1'b0, 1'b0, 2'b11, -1, 1'b0, 1'b1);

    // One-tick glitch in idle: false start only
    wait_tick();
    #1 rx_serial_sync = 1'b0;
    wait_tick();
    #1 rx_serial_sync = 1'b1;
    check("glitch_seen", rx_active, 1'b1);
    repeat (12) wait_tick();
    #1;
    check("glitch_idle", rx_active, 1'b0);
    check("glitch_novalid", rx_valid, 1'b0);

    // Inverted centre sample in data bit 3 of 0x00
    run_frame("vote_00", 9'h000, 8, 2'b00, 1'b0, 1'b0, 2'b11, 4, 1'b0, 1'b1);

    // Overrun sequence
    cfg_data_bits = 4'd8; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      build_frame(9'(i * 'h11), 8, 2'b00, 1'b0, 1'b0, 2'b11);
      send_frame(-1, -1, -1, 1'b0);
      repeat (4) wait_tick();
      #1;
    end
    check("ovr_data", rx_data, 9'h011);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    build_frame(9'h044, 8, 2'b00, 1'b0, 1'b0, 2'b11);
    send_frame(-1, exp_lat - 1, -1, 1'b0);
    #1;
    check("hsload_data", rx_data, 9'h044);
    check("hsload_valid", rx_valid, 1'b1);
    check("hsload_overrun", overrun, 1'b0);
    build_frame(9'h066, 8, 2'b00, 1'b0, 1'b0, 2'b11);
    send_frame(-1, -1, -1, 1'b0);
    #1;
    check("drop_data", rx_data, 9'h044);
    check("drop_overrun", overrun, 1'b1);
    accept();
    repeat (8) wait_tick();
    #1;

    // Reset mid-DATA with a word held, then a clean frame
    build_frame(9'h077, 8, 2'b00, 1'b0, 1'b0, 2'b11);
    send_frame(-1, -1, -1, 1'b0);
    build_frame(9'h05A, 8, 2'b00, 1'b0, 1'b0, 2'b11);
    send_frame(-1, -1, 3 * 16 + 5, 1'b0);
    #2;
    check("abort_valid", rx_valid, 1'b0);
    check("abort_data", rx_data, 9'h000);
    check("abort_flags", {parity_error, frame_error, break_detect, overrun}, 4'b0000);
    check("abort_active", rx_active, 1'b0);
    @(posedge uart_clk);
    #1 rst_n = 1'b1;
    repeat (8) wait_tick();
    #1;
    run_frame("after_rst_3c", 9'h03C, 8, 2'b00, 1'b0, 1'b0, 2'b11, -1, 1'b0, 1'b1);

    // Randomized frames
    for (int i = 0; i < 24; i++) begin
      int n, gb;
      logic [1:0] par, stops;
      logic st2, flip, scr;
      logic [8:0] val;
      n = $urandom_range(0, 15);
      par = 2'($urandom_range(0, 3));
      st2 = 1'($urandom_range(0, 1));
      val = ($urandom_range(0, 3) == 0) ? 9'h000 : 9'($urandom_range(0, 511));
      flip = ($urandom_range(0, 3) == 0);
      stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      gb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : -1;
      scr = 1'($urandom_range(0, 1));
      run_frame("rand", val, n, par, st2, flip, stops, gb, scr, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
